wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the register file's functional-unit write ports among the execution decoders (ALU, FPU, LSU, BRU).
- Each unit pushes its writeback result (phys dest, data, ROB ptr) into a small per-requester queue.
- The arbiter grants up to NUM_PORTS queue heads per cycle, round-robin, and drives registered write-port and ROB-completion outputs.
- Sits between the exec decoders and reg_file/reorder_buffer; replaces one-write-port-per-unit wiring.

Parameters:
- NUM_REQ, 4, number of requesting units (index 0=ALU, 1=FPU, 2=LSU, 3=BRU).
- NUM_PORTS, 2, number of regfile write ports owned by the arbiter (1 <= NUM_PORTS <= NUM_REQ).
- QDEPTH, 2, entries per requester queue (power of 2, >= 2).
- WORD_W, reg_pkg::WORD_SIZE, data width.
- PREG_W, $clog2(reg_pkg::NUM_PHYS_REGS), physical register index width.
- PTR_W, $clog2(rob_pkg::ROB_ENTRIES), ROB pointer width.

Ports:
- clk_in, in, 1, clock; the only clock.
- rst_N_in, in, 1, reset; asynchronous, active-low.
- flush_in, in, 1, synchronous flush of all queued and in-flight writes.
- req_valid_in, in, NUM_REQ, per-unit writeback valid.
- req_ready_out, out, NUM_REQ, per-unit queue can accept.
- req_preg_in, in, NUM_REQ x PREG_W, destination phys reg.
- req_data_in, in, NUM_REQ x WORD_W, result data.
- req_ptr_in, in, NUM_REQ x PTR_W, ROB pointer.
- wr_en_out, out, NUM_PORTS, regfile write enable.
- wr_idx_out, out, NUM_PORTS x PREG_W, write index.
- wr_data_out, out, NUM_PORTS x WORD_W, write data.
- wb_valid_out, out, NUM_PORTS, ROB completion valid (equal to wr_en_out).
- wb_ptr_out, out, NUM_PORTS x PTR_W, ROB pointer completed.
- wb_src_out, out, NUM_PORTS x $clog2(NUM_REQ), granted requester id (debug/verification).

Behaviour:
- Reset (rst_N_in low, async):
  - All queues empty; rr_ptr=0.
  - wr_en_out, wb_valid_out = 0; idx/data/ptr/src outputs = 0.
  - req_ready_out = all 1 after reset deassertion; held 0 while reset is asserted.
- Queues: one circular FIFO per requester with head/tail/count.
  - req_ready_out[i] = (count[i] < QDEPTH); combinational from registered count only, with no dependence on same-cycle pops.
  - Push on req_valid_in[i] && req_ready_out[i]. Valid without ready is ignored (dropped); this is a requester protocol error and the bench asserts it never happens.
- Grant (combinational from current state):
  - Scan requesters starting at rr_ptr, wrapping modulo NUM_REQ.
  - Grant the first min(NUM_PORTS, #non-empty) non-empty queues.
  - Port k receives the k-th grant in scan order.
  - Granted queues pop one entry at the clock edge.
  - At most one pop per queue per cycle, even if ports remain idle.
- Round-robin update: if any grant, rr_ptr <= (last granted index + 1) mod NUM_REQ; else unchanged.
- Outputs: registered. A grant in cycle t gives wr_en_out/wr_* valid for exactly cycle t+1. Unused ports have wr_en_out=0; their idx/data hold their previous values.
- Latency:
  - An entry pushed at edge t is eligible for grant in cycle t+1 (no same-cycle bypass).
  - It appears on a write port at edge t+2 at the earliest.
- Simultaneous push and pop on the same queue: both occur; count unchanged. A full queue still shows ready=0 that cycle.
- Wrap-around: head/tail wrap modulo QDEPTH; count saturates logically at QDEPTH (never exceeds it).
- Flush (flush_in high at edge):
  - All counts = 0; rr_ptr unchanged.
  - Next-cycle wr_en_out/wb_valid_out = 0.
  - Pushes in the flush cycle are discarded.
  - Flush takes priority over push and pop.
- Fairness: with all queues continuously non-empty, each requester is granted at least once every ceil(NUM_REQ/NUM_PORTS) cycles.
- No duplicate indices checking; physical dest uniqueness is guaranteed by rename.

Decomposition:
- Shared package wb_pkg: typedef wb_req_t {preg, data, ptr}; typedef wb_port_t {en, idx, data, ptr, src}; WB_NUM_PORTS constant. Fields are mappable onto reg_pkg::RegFileWritePort.
- One sub-module: wb_req_fifo (parameterised QDEPTH, payload wb_req_t; push/pop/count/full/empty), instantiated NUM_REQ times. Arbiter scan and output registers live in the top.

Test Plan:
- Reset: assert rst_N_in mid-stream with 2 queued entries -> wr_en_out=0 immediately (async); after release, req_ready_out=4'b1111 and no stale writes ever appear.
- Single request: ALU pushes preg=5, data=0xDEAD, ptr=3 at edge 0 -> wr_en_out[0]=1, wr_idx_out[0]=5, wr_data_out[0]=0xDEAD, wb_ptr_out[0]=3 in cycle 2 only; port1 idle.
- Contention: all 4 push in the same cycle, rr_ptr=0 -> next cycle grants 0,1 (port0=ALU, port1=FPU), following cycle grants 2,3; rr_ptr returns to 0.
- Backpressure: LSU pushes 3 consecutive cycles while ports are saturated by others -> req_ready_out[2]=0 once count=2; the third push is withheld by the unit; all LSU entries drain in FIFO order.
- Fairness: all queues kept full for 20 cycles -> each requester granted exactly 10 times, never starved for more than 2 cycles.
- Flush: queue 3 entries across units, assert flush_in with a simultaneous BRU push -> next cycle wr_en_out=0; no flushed or flush-cycle data is ever written; req_ready_out=all 1.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and defaults for the writeback port arbiter.
// Field layout maps onto reg_pkg::RegFileWritePort (en/idx/data) plus ROB completion.
package wb_pkg;
  localparam int WB_NUM_REQ   = 4;
  localparam int WB_NUM_PORTS = 2;
  localparam int WB_QDEPTH    = 2;
  // Defaults track reg_pkg::WORD_SIZE, NUM_PHYS_REGS and rob_pkg::ROB_ENTRIES
  localparam int WB_WORD_W    = 32;
  localparam int WB_PREG_W    = 6;
  localparam int WB_PTR_W     = 5;
  localparam int WB_SRC_W     = $clog2(WB_NUM_REQ);

  typedef enum logic [1:0] {
    REQ_ALU = 2'd0,
    REQ_FPU = 2'd1,
    REQ_LSU = 2'd2,
    REQ_BRU = 2'd3
  } wb_unit_e;

  typedef struct packed {
    logic [WB_PREG_W-1:0] preg;
    logic [WB_WORD_W-1:0] data;
    logic [WB_PTR_W-1:0]  ptr;
  } wb_req_t;

  typedef struct packed {
    logic                 en;
    logic [WB_PREG_W-1:0] idx;
    logic [WB_WORD_W-1:0] data;
    logic [WB_PTR_W-1:0]  ptr;
    logic [WB_SRC_W-1:0]  src;
  } wb_port_t;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/wb_req_fifo.sv
// Per-requester circular writeback queue; head entry is visible combinationally
// so the arbiter can grant and forward it in the same cycle.
module wb_req_fifo
  import wb_pkg::*;
#(
  parameter int  QDEPTH    = WB_QDEPTH,
  parameter type payload_t = wb_req_t,
  localparam int IDX_W     = $clog2(QDEPTH),
  localparam int CNT_W     = $clog2(QDEPTH + 1)
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             flush_in,
  input  logic             push_in,
  input  payload_t         push_data_in,
  input  logic             pop_in,
  output payload_t         head_out,
  output logic [CNT_W-1:0] count_out,
  output logic             empty_out
);
  payload_t         mem_q [QDEPTH];
  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push = push_in && (count_q != CNT_W'(QDEPTH)) && !flush_in;
    do_pop  = pop_in && (count_q != '0) && !flush_in;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_in) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) tail_d = tail_q + IDX_W'(1);
      if (do_pop)  head_d = head_q + IDX_W'(1);
      if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
      else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: stale entries are never visible while count is zero.
  always_ff @(posedge clk_in) begin
    if (do_push) mem_q[tail_q] <= push_data_in;
  end

  assign head_out  = mem_q[head_q];
  assign count_out = count_q;
  assign empty_out = (count_q == '0);
endmodule

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing NUM_PORTS register-file write ports among the
// execution units' writeback queues; write-port and ROB outputs are registered.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int  NUM_REQ   = WB_NUM_REQ,
  parameter int  NUM_PORTS = WB_NUM_PORTS,
  parameter int  QDEPTH    = WB_QDEPTH,
  parameter int  WORD_W    = WB_WORD_W,
  parameter int  PREG_W    = WB_PREG_W,
  parameter int  PTR_W     = WB_PTR_W,
  localparam int SRC_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W     = $clog2(QDEPTH + 1)
) (
  input  logic                              clk_in,
  input  logic                              rst_N_in,
  input  logic                              flush_in,
  input  logic [NUM_REQ-1:0]                req_valid_in,
  output logic [NUM_REQ-1:0]                req_ready_out,
  input  logic [NUM_REQ-1:0][PREG_W-1:0]    req_preg_in,
  input  logic [NUM_REQ-1:0][WORD_W-1:0]    req_data_in,
  input  logic [NUM_REQ-1:0][PTR_W-1:0]     req_ptr_in,
  output logic [NUM_PORTS-1:0]              wr_en_out,
  output logic [NUM_PORTS-1:0][PREG_W-1:0]  wr_idx_out,
  output logic [NUM_PORTS-1:0][WORD_W-1:0]  wr_data_out,
  output logic [NUM_PORTS-1:0]              wb_valid_out,
  output logic [NUM_PORTS-1:0][PTR_W-1:0]   wb_ptr_out,
  output logic [NUM_PORTS-1:0][SRC_W-1:0]   wb_src_out
);
  typedef struct packed {
    logic [PREG_W-1:0] preg;
    logic [WORD_W-1:0] data;
    logic [PTR_W-1:0]  ptr;
  } req_t;

  typedef struct packed {
    logic              en;
    logic [PREG_W-1:0] idx;
    logic [WORD_W-1:0] data;
    logic [PTR_W-1:0]  ptr;
    logic [SRC_W-1:0]  src;
  } port_t;

  req_t                        head [NUM_REQ];
  logic [CNT_W-1:0]            count [NUM_REQ];
  logic [NUM_REQ-1:0]          empty;
  logic [NUM_REQ-1:0]          push;
  logic [NUM_REQ-1:0]          pop;
  port_t [NUM_PORTS-1:0]       port_q, port_d;
  logic [SRC_W-1:0]            rr_q, rr_d;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      req_t push_data;
      assign push_data = '{preg: req_preg_in[gi], data: req_data_in[gi], ptr: req_ptr_in[gi]};
      // Ready looks only at the registered count, never at this cycle's pop.
      assign req_ready_out[gi] = (count[gi] != CNT_W'(QDEPTH)) && rst_N_in;
      assign push[gi]          = req_valid_in[gi] && req_ready_out[gi];

      wb_req_fifo #(
        .QDEPTH   (QDEPTH),
        .payload_t(req_t)
      ) u_fifo (
        .clk_in      (clk_in),
        .rst_n_in    (rst_N_in),
        .flush_in    (flush_in),
        .push_in     (push[gi]),
        .push_data_in(push_data),
        .pop_in      (pop[gi]),
        .head_out    (head[gi]),
        .count_out   (count[gi]),
        .empty_out   (empty[gi])
      );
    end
  endgenerate

  always_comb begin
    int idx;
    int n;
    pop  = '0;
    rr_d = rr_q;
    n    = 0;
    idx  = 0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_d[p]    = port_q[p];
      port_d[p].en = 1'b0;
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      idx = int'(rr_q) + j;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!empty[idx] && n < NUM_PORTS) begin
        pop[idx]  = 1'b1;
        port_d[n] = '{en: 1'b1, idx: head[idx].preg, data: head[idx].data,
                      ptr: head[idx].ptr, src: SRC_W'(idx)};
        rr_d      = SRC_W'(wrap_inc(idx, NUM_REQ));
        n         = n + 1;
      end
    end
    // Flush drops everything in flight but leaves the fairness pointer alone.
    if (flush_in) begin
      pop  = '0;
      rr_d = rr_q;
      for (int p = 0; p < NUM_PORTS; p++) begin
        port_d[p]    = port_q[p];
        port_d[p].en = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      port_q <= '0;
      rr_q   <= '0;
    end else begin
      port_q <= port_d;
      rr_q   <= rr_d;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign wr_en_out[gi]    = port_q[gi].en;
      assign wb_valid_out[gi] = port_q[gi].en;
      assign wr_idx_out[gi]   = port_q[gi].idx;
      assign wr_data_out[gi]  = port_q[gi].data;
      assign wb_ptr_out[gi]   = port_q[gi].ptr;
      assign wb_src_out[gi]   = port_q[gi].src;
    end
  endgenerate
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed scoreboard bench for wb_port_arbiter: stimulus queues expected writes
// (port, cycle, fields) and a negedge monitor pops and compares each write seen.
module tb_wb_port_arbiter;
  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic [3:0]       req_valid;
  logic [3:0]       req_ready;
  logic [3:0][5:0]  req_preg;
  logic [3:0][31:0] req_data;
  logic [3:0][4:0]  req_ptr;
  logic [1:0]       wr_en;
  logic [1:0][5:0]  wr_idx;
  logic [1:0][31:0] wr_data;
  logic [1:0]       wb_valid;
  logic [1:0][4:0]  wb_ptr;
  logic [1:0][1:0]  wb_src;

  typedef struct {
    int          port;
    int          cyc;
    logic [5:0]  idx;
    logic [31:0] data;
    logic [4:0]  ptr;
    logic [1:0]  src;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   fair_on = 1'b0;
  int   fair_lo, fair_hi, fair_gap_bad;
  int   fair_cnt[4];
  int   fair_last[4];

  wb_port_arbiter dut (
    .clk_in       (clk),
    .rst_N_in     (rst_n),
    .flush_in     (flush),
    .req_valid_in (req_valid),
    .req_ready_out(req_ready),
    .req_preg_in  (req_preg),
    .req_data_in  (req_data),
    .req_ptr_in   (req_ptr),
    .wr_en_out    (wr_en),
    .wr_idx_out   (wr_idx),
    .wr_data_out  (wr_data),
    .wb_valid_out (wb_valid),
    .wb_ptr_out   (wb_ptr),
    .wb_src_out   (wb_src)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [5:0] enc_preg(input int u, input int s);
    return 6'(u * 16 + (s % 16));
  endfunction
  function automatic logic [31:0] enc_data(input int u, input int s);
    return 32'hC000_0000 | 32'(u << 16) | 32'(s);
  endfunction
  function automatic logic [4:0] enc_ptr(input int u, input int s);
    return 5'((u * 8 + s) % 32);
  endfunction

  task automatic set_req(input int u, input logic [5:0] p, input logic [31:0] d, input logic [4:0] r);
    req_valid[u] = 1'b1;
    req_preg[u]  = p;
    req_data[u]  = d;
    req_ptr[u]   = r;
  endtask

  task automatic set_enc(input int u, input int s);
    set_req(u, enc_preg(u, s), enc_data(u, s), enc_ptr(u, s));
  endtask

  task automatic exp_raw(input int port, input int c, input logic [5:0] p,
                         input logic [31:0] d, input logic [4:0] r, input logic [1:0] src);
    exp_t x;
    x.port = port; x.cyc = c; x.idx = p; x.data = d; x.ptr = r; x.src = src;
    sb.push_back(x);
  endtask

  task automatic exp_enc(input int port, input int c, input int u, input int s);
    exp_raw(port, c, enc_preg(u, s), enc_data(u, s), enc_ptr(u, s), 2'(u));
  endtask

  // Issue whatever is set up, across one clock edge; a unit never drives valid without ready.
  task automatic tick();
    for (int u = 0; u < 4; u++)
      if (req_valid[u]) chk($sformatf("push_ready_u%0d", u), 64'(req_ready[u]), 64'd1);
    @(posedge clk);
    #1;
    req_valid = '0;
    flush     = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("wb_valid_p%0d", p), 64'(wb_valid[p]), 64'(wr_en[p]));
        if (wr_en[p]) begin
          $display("write cyc=%0d port=%0d src=%0d idx=%0d data=%08h ptr=%0d",
                   cyc, p, wb_src[p], wr_idx[p], wr_data[p], wb_ptr[p]);
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: port=%0d idx=%0d got en=1 required en=0 (cyc %0d)",
                     p, wr_idx[p], cyc);
          end else begin
            e = sb.pop_front();
            chk("port", 64'(p), 64'(e.port));
            chk("cycle", 64'(cyc), 64'(e.cyc));
            chk("wr_idx", 64'(wr_idx[p]), 64'(e.idx));
            chk("wr_data", 64'(wr_data[p]), 64'(e.data));
            chk("wb_ptr", 64'(wb_ptr[p]), 64'(e.ptr));
            chk("wb_src", 64'(wb_src[p]), 64'(e.src));
          end
          if (fair_on && cyc >= fair_lo && cyc <= fair_hi) begin
            fair_cnt[wb_src[p]]++;
            if (cyc - fair_last[wb_src[p]] > 2) fair_gap_bad++;
            fair_last[wb_src[p]] = cyc;
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    int sent[4];
    rst_n     = 1'b0;
    flush     = 1'b0;
    req_valid = '0;
    req_preg  = '0;
    req_data  = '0;
    req_ptr   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_wr_idx", 64'(wr_idx), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    chk("rst_ptr_src", 64'({wb_ptr, wb_src}), 64'd0);
    chk("rst_ready_held", 64'(req_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", 64'(req_ready), 64'hF);
    @(posedge clk);
    #1;

    // Single ALU write, port 0 only, one cycle after the push edge's successor.
    set_req(0, 6'd5, 32'hDEAD, 5'd3);
    tick();
    p = cyc;
    exp_raw(0, p + 1, 6'd5, 32'hDEAD, 5'd3, 2'd0);
    idle(4);

    // BRU alone moves rr_ptr to 0.
    set_enc(3, 0);
    tick();
    p = cyc;
    exp_enc(0, p + 1, 3, 0);
    idle(3);

    // Contention: all four at once from rr_ptr=0.
    for (int u = 0; u < 4; u++) set_enc(u, 1);
    tick();
    p = cyc;
    exp_enc(0, p + 1, 0, 1);
    exp_enc(1, p + 1, 1, 1);
    exp_enc(0, p + 2, 2, 1);
    exp_enc(1, p + 2, 3, 1);
    idle(4);

    // Backpressure on LSU while ALU/FPU compete.
    set_enc(0, 2); set_enc(1, 2); set_enc(2, 2);
    tick();
    p = cyc;
    exp_enc(0, p + 1, 0, 2); exp_enc(1, p + 1, 1, 2);
    exp_enc(0, p + 2, 2, 2); exp_enc(1, p + 2, 0, 3);
    exp_enc(0, p + 3, 1, 3); exp_enc(1, p + 3, 2, 3);
    exp_enc(0, p + 4, 0, 4); exp_enc(1, p + 4, 1, 4);
    exp_enc(0, p + 5, 2, 4);
    set_enc(0, 3); set_enc(1, 3); set_enc(2, 3);
    tick();
    chk("lsu_ready_full", 64'(req_ready[2]), 64'd0);
    set_enc(0, 4); set_enc(1, 4);
    tick();
    chk("lsu_ready_again", 64'(req_ready[2]), 64'd1);
    set_enc(2, 4);
    tick();
    idle(6);

    // Fairness: every queue refilled whenever ready, 11 entries each, from rr_ptr=3.
    for (int u = 0; u < 4; u++) sent[u] = 0;
    p = 0;
    for (int c = 0; c < 40; c++) begin
      if (sent[0] == 11 && sent[1] == 11 && sent[2] == 11 && sent[3] == 11) break;
      for (int u = 0; u < 4; u++)
        if (req_ready[u] && sent[u] < 11) begin
          set_enc(u, 5 + sent[u]);
          sent[u]++;
        end
      tick();
      if (c == 0) begin
        p = cyc;
        for (int k = 2; k <= 23; k++) begin
          if (k % 2 == 0) begin
            exp_enc(0, p + k - 1, 3, 5 + (k - 2) / 2);
            exp_enc(1, p + k - 1, 0, 5 + (k - 2) / 2);
          end else begin
            exp_enc(0, p + k - 1, 1, 5 + (k - 3) / 2);
            exp_enc(1, p + k - 1, 2, 5 + (k - 3) / 2);
          end
        end
        fair_lo      = p + 1;
        fair_hi      = p + 20;
        fair_gap_bad = 0;
        for (int u = 0; u < 4; u++) begin
          fair_cnt[u]  = 0;
          fair_last[u] = p;
        end
        fair_on = 1'b1;
      end
    end
    idle(6);
    fair_on = 1'b0;
    for (int u = 0; u < 4; u++) chk($sformatf("fair_grants_u%0d", u), 64'(fair_cnt[u]), 64'd10);
    chk("fair_max_gap", 64'(fair_gap_bad), 64'd0);

    // Flush with a simultaneous BRU push; nothing of it may ever be written.
    set_enc(0, 20); set_enc(1, 20); set_enc(2, 20);
    tick();
    flush = 1'b1;
    set_enc(3, 20);
    tick();
    chk("flush_wr_en", 64'(wr_en), 64'd0);
    chk("flush_ready", 64'(req_ready), 64'hF);
    idle(4);
    // rr_ptr survives the flush at 3: BRU goes to port 0 ahead of ALU.
    set_enc(0, 21); set_enc(3, 21);
    tick();
    p = cyc;
    exp_enc(0, p + 1, 3, 21);
    exp_enc(1, p + 1, 0, 21);
    idle(3);

    // Async reset mid-stream with ALU still queued behind FPU/LSU.
    set_enc(0, 22); set_enc(1, 22); set_enc(2, 22);
    tick();
    p = cyc;
    exp_enc(0, p + 1, 1, 22);
    exp_enc(1, p + 1, 2, 22);
    @(posedge clk);
    #7;
    rst_n = 1'b0;
    #1;
    chk("async_rst_wr_en", 64'(wr_en), 64'd0);
    chk("async_rst_wr_idx", 64'(wr_idx), 64'd0);
    chk("async_rst_ready", 64'(req_ready), 64'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    chk("ready_after_rerst", 64'(req_ready), 64'hF);
    idle(6);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
